display_sync_decoder: RTL and testbench
=======================================

# display_sync_decoder

Recovers display coordinates and timing from a VGA-style pixel stream (hsync, vsync, de, RGB) at the receiving end of the display interface. It regenerates `sx`/`sy` for active pixels, emits `frame` and `line` pulses, measures active width and height, and asserts `locked` once the incoming timing has matched the expected resolution for enough consecutive frames. It sits downstream of a display timing generator or capture front-end and feeds capture, scaling or checking logic that needs coordinates.

## Interface
Parameters:
- `CORDW`, 16: coordinate and measurement width in bits.
- `H_RES`, 640: expected active pixels per line.
- `V_RES`, 480: expected active lines per frame.
- `HS_POL`, 0: hsync active level (0 = active-low).
- `VS_POL`, 0: vsync active level (0 = active-low).
- `LOCK_FRAMES`, 2: consecutive good frames required to lock (≥1).
- `TIMEOUT`, 1048576: clock cycles without a vsync leading edge before lock is abandoned.

Ports:
- `clk_pix` in 1: pixel clock, the same clock as the source stream.
- `rst_pix_n` in 1: reset, asynchronous and active-low.
- `hsync`, `vsync`, `de` in 1 each: incoming sync and data enable.
- `in_r`, `in_g`, `in_b` in 4 each: incoming colour.
- `sx`, `sy` out CORDW: unsigned coordinates of the current output pixel.
- `out_de` out 1: output pixel is active.
- `out_r`, `out_g`, `out_b` out 4 each: delayed colour, aligned with `sx`/`sy`.
- `frame` out 1: one-cycle pulse on the vsync leading edge.
- `line` out 1: one-cycle pulse on the de rising edge.
- `h_meas`, `v_meas` out CORDW: last measured active width and height.
- `locked` out 1: stable timing at H_RES×V_RES.

## Operation
- Stage 1 registers all inputs. Edge detection compares stage 1 with a delayed copy.
- vs_edge is the stage-1 vsync changing to active level VS_POL. de_rise and de_fall follow the same pattern.
- hsync is registered and polarity-checked only. Coordinates come from de.
- The x counter clears on de_rise and increments while de is high. It saturates at 2^CORDW−1.
- The line counter clears on vs_edge and increments on each de_fall. It saturates at 2^CORDW−1.
- `sx` shows the x count for the current pixel, starting at 0 on the first active pixel. `sy` shows the line count of the current line, starting at 0 on the first active line after vs_edge.
- On de_fall, `h_meas` loads the pixel count of the line just ended. If that count ≠ H_RES, the frame error flag `ferr` is set.
- On vs_edge, `v_meas` loads the line count. If the line count ≠ V_RES, the frame is bad. A frame with `ferr` set is also bad. `ferr` then clears.
- Lock state machine:
  - SEARCH (reset state): on vs_edge go to TRACK with good=0. The partial frame before it is not evaluated.
  - TRACK: on vs_edge, a good frame increments good. When good reaches LOCK_FRAMES, go to LOCKED. A bad frame sets good=0.
  - LOCKED: a bad frame at vs_edge returns to TRACK with good=0.
  - Any state except SEARCH: a timeout counter reaches TIMEOUT with no vs_edge, then go to SEARCH with good=0.
  - The timeout counter clears on every vs_edge.
- `locked` is 1 only in LOCKED.

## Timing
- `out_*`, `sx`, `sy`, `frame` and `line` appear 2 cycles after the corresponding input sample.
- `h_meas` updates 2 cycles after the first de-low input sample.
- `v_meas` and state changes take effect 2 cycles after the vsync-active input sample. `locked` follows one cycle later.
- With the default LOCK_FRAMES=2, `locked` rises after the 3rd vs_edge following reset. vs_edge 1 enters TRACK, edges 2 and 3 evaluate good frames.
- If vs_edge and de_fall coincide, the de_fall measurement is counted in the closing frame.
- Reset: every output is 0, state is SEARCH, all counters are 0, and `ferr` is 0. Asserting reset mid-frame discards all partial measurement.

## Test plan
- Nominal 640×480 stream (800×525 total) for 4 frames:
  - `sx` runs 0..639 and `sy` runs 0..479.
  - `h_meas`=640 and `v_meas`=480.
  - `locked` rises 3 cycles after the 3rd vsync-active input sample.
- Locked stream, then one line with 639 active pixels: `locked` falls at that frame's vs_edge. It returns after 2 further good frames.
- Locked stream, then a frame with 479 lines: `v_meas`=479 and `locked` drops. It relocks after 2 good frames.
- Vsync held inactive with TIMEOUT=1000: `locked` deasserts 1000 cycles after the last vs_edge. The next vs_edge leaves SEARCH for TRACK only.
- `rst_pix_n` pulsed low mid-line: all outputs are 0 immediately, without a clock edge. The following frame is not evaluated.
- Run with HS_POL=VS_POL=1 and inverted syncs: results are identical to the nominal run. RGB pattern 4'hA/5/F appears on `out_*` exactly 2 cycles late.

Source files
------------

// File: rtl/display_sync_decoder_if.sv
// Pixel-stream bundle for display_sync_decoder.
//   master : stream source / result consumer (drives hsync, vsync, de, in_*)
//   slave  : the decoder (drives sx, sy, out_*, frame, line, h_meas, v_meas, locked)
interface display_sync_decoder_if #(
  parameter int CORDW = 16
);
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [3:0]       in_r;
  logic [3:0]       in_g;
  logic [3:0]       in_b;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             out_de;
  logic [3:0]       out_r;
  logic [3:0]       out_g;
  logic [3:0]       out_b;
  logic             frame;
  logic             line;
  logic [CORDW-1:0] h_meas;
  logic [CORDW-1:0] v_meas;
  logic             locked;

  modport master (
    output hsync, vsync, de, in_r, in_g, in_b,
    input  sx, sy, out_de, out_r, out_g, out_b, frame, line, h_meas, v_meas, locked
  );

  modport slave (
    input  hsync, vsync, de, in_r, in_g, in_b,
    output sx, sy, out_de, out_r, out_g, out_b, frame, line, h_meas, v_meas, locked
  );
endinterface

// File: rtl/display_sync_decoder.sv
// Recovers sx/sy, frame/line pulses, active width/height and a lock flag
// from a VGA-style pixel stream.
//   clk_pix   : pixel clock of the incoming stream
//   rst_pix_n : asynchronous active-low reset
//   bus       : slave side of display_sync_decoder_if (stream in, results out)
// Pixel outputs lag the input by 2 cycles; locked lags the lock state by 1.
module display_sync_decoder #(
  parameter int CORDW       = 16,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1048576
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix_n,
  display_sync_decoder_if.slave bus
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CORDW-1:0] CMAX = '1;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_t;

  logic             s1_hs, s1_vs, s1_de;
  logic [3:0]       s1_r, s1_g, s1_b;
  logic             d_vs, d_de;
  logic             hs_act, vs_edge, de_rise, de_fall;
  logic [CORDW-1:0] x_q, y_q, sy_q, x_next, y_next, lines_total;
  logic [CORDW-1:0] h_meas_q, v_meas_q;
  logic             ferr_q, h_bad, frame_bad;
  logic             out_de_q, frame_q, line_q, locked_q;
  logic [3:0]       out_r_q, out_g_q, out_b_q;
  lock_state_t      state_q, state_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [TW-1:0]    to_q;
  logic             to_hit;

  // Stage 1 plus the delayed copy used for edge detection
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_de <= 1'b0;
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
      d_vs  <= 1'b0;
      d_de  <= 1'b0;
    end else begin
      s1_hs <= bus.hsync;
      s1_vs <= bus.vsync;
      s1_de <= bus.de;
      s1_r  <= bus.in_r;
      s1_g  <= bus.in_g;
      s1_b  <= bus.in_b;
      d_vs  <= s1_vs;
      d_de  <= s1_de;
    end
  end

  always_comb begin
    hs_act      = (s1_hs == HS_POL);
    vs_edge     = (s1_vs == VS_POL) && (d_vs != VS_POL);
    de_rise     = s1_de && !d_de;
    de_fall     = !s1_de && d_de;
    x_next      = (x_q == CMAX) ? CMAX : x_q + 1'b1;
    y_next      = (y_q == CMAX) ? CMAX : y_q + 1'b1;
    // A de_fall coinciding with vs_edge still belongs to the closing frame
    lines_total = de_fall ? y_next : y_q;
    h_bad       = de_fall && (x_next != CORDW'(H_RES));
    frame_bad   = ferr_q || h_bad || (lines_total != CORDW'(V_RES));
  end

  // hsync only carries polarity; coordinates are derived from de alone
  a_hs_outside_de: assert property (@(posedge clk_pix) disable iff (!rst_pix_n)
    !(hs_act && s1_de));

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      x_q      <= '0;
      y_q      <= '0;
      sy_q     <= '0;
      h_meas_q <= '0;
      v_meas_q <= '0;
      ferr_q   <= 1'b0;
      out_de_q <= 1'b0;
      out_r_q  <= '0;
      out_g_q  <= '0;
      out_b_q  <= '0;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
    end else begin
      // x_q is written in the same edge as out_de, so it already aligns with it
      if (de_rise)     x_q <= '0;
      else if (s1_de)  x_q <= x_next;
      if (vs_edge)      y_q <= '0;
      else if (de_fall) y_q <= y_next;
      sy_q <= y_q;
      // Pixel count of the ended line is last x + 1
      if (de_fall) h_meas_q <= x_next;
      if (vs_edge) v_meas_q <= lines_total;
      if (vs_edge)    ferr_q <= 1'b0;
      else if (h_bad) ferr_q <= 1'b1;
      out_de_q <= s1_de;
      out_r_q  <= s1_r;
      out_g_q  <= s1_g;
      out_b_q  <= s1_b;
      frame_q  <= vs_edge;
      line_q   <= de_rise;
    end
  end

  assign good_inc = good_q + 1'b1;
  assign to_hit   = (to_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (vs_edge) begin
          if (frame_bad) begin
            good_d = '0;
          end else begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_FRAMES)) state_d = LOCKED;
          end
        end else if (to_hit) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      LOCKED: begin
        if (vs_edge) begin
          if (frame_bad) begin
            state_d = TRACK;
            good_d  = '0;
          end
        end else if (to_hit) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      to_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      if (vs_edge || state_q == SEARCH) to_q <= '0;
      else if (!to_hit)                 to_q <= to_q + 1'b1;
      locked_q <= (state_q == LOCKED);
    end
  end

  assign bus.sx     = x_q;
  assign bus.sy     = sy_q;
  assign bus.out_de = out_de_q;
  assign bus.out_r  = out_r_q;
  assign bus.out_g  = out_g_q;
  assign bus.out_b  = out_b_q;
  assign bus.frame  = frame_q;
  assign bus.line   = line_q;
  assign bus.h_meas = h_meas_q;
  assign bus.v_meas = v_meas_q;
  assign bus.locked = locked_q;
endmodule

// File: tb/tb_display_sync_decoder.sv
// Bench for display_sync_decoder: two instances (active-low and active-high
// syncs) fed the same scaled-down stream (16x8 active, 24x12 total).
module tb_display_sync_decoder;
  localparam int CORDW = 16;
  localparam int H_RES = 16;
  localparam int V_RES = 8;
  localparam int H_TOT = 24;
  localparam int V_TOT = 12;
  localparam int LOCK_FRAMES = 2;
  localparam int TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_sync_decoder_if #(.CORDW(CORDW)) bus0 ();
  display_sync_decoder_if #(.CORDW(CORDW)) bus1 ();

  display_sync_decoder #(.CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .HS_POL(1'b0),
    .VS_POL(1'b0), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT))
    dut0 (.clk_pix(clk), .rst_pix_n(rst_n), .bus(bus0));

  display_sync_decoder #(.CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .HS_POL(1'b1),
    .VS_POL(1'b1), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT))
    dut1 (.clk_pix(clk), .rst_pix_n(rst_n), .bus(bus1));

  typedef struct {
    int          due;
    logic        de;
    logic        frame;
    logic        line;
    logic        lock;
    logic [11:0] rgb;
    logic [15:0] sx;
    logic [15:0] sy;
    logic [15:0] hm;
    logic [15:0] vm;
  } exp_t;

  typedef enum {M_SEARCH, M_TRACK, M_LOCKED} mstate_t;

  exp_t    q[$];
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  bit      m_prev_vs, m_prev_de, m_ferr, m_lock_prev;
  int      m_px, m_lines, m_hm, m_vm, m_since, m_good;
  mstate_t m_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    m_prev_vs = 0; m_prev_de = 0; m_ferr = 0; m_lock_prev = 0;
    m_px = 0; m_lines = 0; m_hm = 0; m_vm = 0; m_since = 0; m_good = 0;
    m_st = M_SEARCH;
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " sx0"}, bus0.sx, 0);         chk({tag, " sx1"}, bus1.sx, 0);
    chk({tag, " sy0"}, bus0.sy, 0);         chk({tag, " sy1"}, bus1.sy, 0);
    chk({tag, " de0"}, bus0.out_de, 0);     chk({tag, " de1"}, bus1.out_de, 0);
    chk({tag, " rgb0"}, {bus0.out_r, bus0.out_g, bus0.out_b}, 0);
    chk({tag, " rgb1"}, {bus1.out_r, bus1.out_g, bus1.out_b}, 0);
    chk({tag, " frame0"}, bus0.frame, 0);   chk({tag, " frame1"}, bus1.frame, 0);
    chk({tag, " line0"}, bus0.line, 0);     chk({tag, " line1"}, bus1.line, 0);
    chk({tag, " hm0"}, bus0.h_meas, 0);     chk({tag, " hm1"}, bus1.h_meas, 0);
    chk({tag, " vm0"}, bus0.v_meas, 0);     chk({tag, " vm1"}, bus1.v_meas, 0);
    chk({tag, " lock0"}, bus0.locked, 0);   chk({tag, " lock1"}, bus1.locked, 0);
  endtask

  task automatic check_exp(input exp_t e);
    chk("out_de0", bus0.out_de, e.de);      chk("out_de1", bus1.out_de, e.de);
    chk("rgb0", {bus0.out_r, bus0.out_g, bus0.out_b}, e.rgb);
    chk("rgb1", {bus1.out_r, bus1.out_g, bus1.out_b}, e.rgb);
    chk("frame0", bus0.frame, e.frame);     chk("frame1", bus1.frame, e.frame);
    chk("line0", bus0.line, e.line);        chk("line1", bus1.line, e.line);
    chk("h_meas0", bus0.h_meas, e.hm);      chk("h_meas1", bus1.h_meas, e.hm);
    chk("v_meas0", bus0.v_meas, e.vm);      chk("v_meas1", bus1.v_meas, e.vm);
    chk("locked0", bus0.locked, e.lock);    chk("locked1", bus1.locked, e.lock);
    if (e.de) begin
      chk("sx0", bus0.sx, e.sx);            chk("sx1", bus1.sx, e.sx);
      chk("sy0", bus0.sy, e.sy);            chk("sy1", bus1.sy, e.sy);
    end
  endtask

  // hs/vs/de are logical "active" levels; dut0 sees them inverted
  task automatic drive(input bit hs, input bit vs, input bit de, input logic [11:0] rgb);
    exp_t e;
    bit vs_edge, de_rise, de_fall, bad_frame;
    bus0.hsync = ~hs; bus0.vsync = ~vs; bus0.de = de;
    bus1.hsync = hs;  bus1.vsync = vs;  bus1.de = de;
    {bus0.in_r, bus0.in_g, bus0.in_b} = rgb;
    {bus1.in_r, bus1.in_g, bus1.in_b} = rgb;
    vs_edge = vs && !m_prev_vs;
    de_rise = de && !m_prev_de;
    de_fall = !de && m_prev_de;
    e.due = cyc + 2; e.de = de; e.rgb = rgb; e.frame = vs_edge; e.line = de_rise;
    e.lock = m_lock_prev;
    if (de) m_px = de_rise ? 0 : m_px + 1;
    e.sx = 16'(m_px);
    e.sy = 16'(m_lines);
    if (de_fall) begin
      m_hm = m_px + 1;
      if (m_hm != H_RES) m_ferr = 1;
      m_lines++;
    end
    if (vs_edge) begin
      bad_frame = m_ferr || (m_lines != V_RES);
      m_vm = m_lines; m_lines = 0; m_ferr = 0; m_since = 0;
      if (m_st == M_SEARCH || bad_frame) begin
        m_st = M_TRACK; m_good = 0;
      end else if (m_st == M_TRACK) begin
        m_good++;
        if (m_good == LOCK_FRAMES) m_st = M_LOCKED;
      end
    end else begin
      m_since++;
      if (m_since == TIMEOUT && m_st != M_SEARCH) begin
        m_st = M_SEARCH; m_good = 0;
      end
    end
    e.hm = 16'(m_hm);
    e.vm = 16'(m_vm);
    m_lock_prev = (m_st == M_LOCKED);
    m_prev_vs = vs;
    m_prev_de = de;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check_exp(e);
    end
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    reset_model();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  task automatic frame_gen(input int nl, input int short_row, input bit vs_on,
                           input int rst_row, input int rst_col, input bit pat);
    bit de, hs, vs;
    logic [11:0] rgb;
    for (int r = 0; r < V_TOT; r++) begin
      for (int c = 0; c < H_TOT; c++) begin
        if (r == rst_row && c == rst_col) pulse_reset();
        de  = (r < nl) && (c < ((r == short_row) ? H_RES - 1 : H_RES));
        hs  = (c >= 18) && (c < 21);
        vs  = vs_on && (r == 9 || r == 10);
        rgb = pat ? (de ? 12'hA5F : 12'h000) : 12'($urandom);
        drive(hs, vs, de, rgb);
      end
    end
  endtask

  initial begin
    bus0.hsync = 1'b1; bus0.vsync = 1'b1; bus0.de = 1'b0;
    bus1.hsync = 1'b0; bus1.vsync = 1'b0; bus1.de = 1'b0;
    {bus0.in_r, bus0.in_g, bus0.in_b} = '0;
    {bus1.in_r, bus1.in_g, bus1.in_b} = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    reset_model();
    // Nominal: lock after the 3rd vsync edge
    for (int f = 0; f < 4; f++) frame_gen(V_RES, -1, 1'b1, -1, -1, f[0]);
    // One 15-pixel line drops lock; two good frames relock
    frame_gen(V_RES, 3, 1'b1, -1, -1, 1'b0);
    for (int f = 0; f < 3; f++) frame_gen(V_RES, -1, 1'b1, -1, -1, 1'b1);
    // Short frame (7 lines)
    frame_gen(V_RES - 1, -1, 1'b1, -1, -1, 1'b0);
    for (int f = 0; f < 3; f++) frame_gen(V_RES, -1, 1'b1, -1, -1, 1'b0);
    // Vsync missing long enough to time out, then recovery
    for (int f = 0; f < 4; f++) frame_gen(V_RES, -1, 1'b0, -1, -1, 1'b0);
    for (int f = 0; f < 4; f++) frame_gen(V_RES, -1, 1'b1, -1, -1, 1'b1);
    // Mid-line asynchronous reset
    frame_gen(V_RES, -1, 1'b1, 4, 5, 1'b0);
    for (int f = 0; f < 3; f++) frame_gen(V_RES, -1, 1'b1, -1, -1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
